// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter: station id mapping and default sizing.
package cdb_arbiter_pkg;

   localparam int RES_INVALID               = 0;
   localparam int CDB_NUM_REQ               = 16;
   localparam int CDB_CF_BASE               = 12;
   localparam int NUM_CONTROL_FLOW_STATIONS = 4;
   localparam int CDB_STARVE_LIMIT          = 4;

   // Station id seen by the RS groups; id 0 is reserved for "no station".
   function automatic int rs_id_of_req(input int i);
      return i + 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Round-robin search: first set request at or after ptr, wrapping modulo N.
module cdb_arbiter_rr_pick #(
   parameter int N  = 16,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          found,
   output logic [PW-1:0] idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      // Walk offsets from far to near so the closest hit to ptr is written last.
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) begin
            found = 1'b1;
            idx   = PW'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Single-winner CDB arbiter: starvation-forced stations first, then control-flow
// round robin, then general round robin. Grant is combinational from req and state.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = CDB_NUM_REQ,
   parameter int CF_BASE      = CDB_CF_BASE,
   parameter int NUM_CF       = NUM_CONTROL_FLOW_STATIONS,
   parameter int STARVE_LIMIT = CDB_STARVE_LIMIT
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               cdb_hold,
   input  logic               flush,
   output logic [31:0]        selection,
   output logic               sel_load,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_cf
);

   localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = (NUM_CF > 1) ? $clog2(NUM_CF) : 1;
   localparam int AW = $clog2(STARVE_LIMIT + 1);
   localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_LIMIT);

   logic [RW-1:0]              rr_ptr_reg, rr_ptr_next;
   logic [CW-1:0]              cf_ptr_reg, cf_ptr_next;
   logic [NUM_REQ-1:0][AW-1:0] age_reg, age_next;

   logic [NUM_REQ-1:0] forced_vec;
   logic               forced_found;
   logic [RW-1:0]      forced_idx;
   logic               cf_found, rr_found;
   logic [CW-1:0]      cf_idx;
   logic [RW-1:0]      rr_idx;
   logic [RW-1:0]      win_idx;
   logic [CW-1:0]      win_cf_off;
   logic               win_cf;
   logic               grant_valid;

   cdb_arbiter_rr_pick #(.N(NUM_CF), .PW(CW)) u_cf_pick (
      .req   (req[CF_BASE +: NUM_CF]),
      .ptr   (cf_ptr_reg),
      .found (cf_found),
      .idx   (cf_idx)
   );

   cdb_arbiter_rr_pick #(.N(NUM_REQ), .PW(RW)) u_rr_pick (
      .req   (req),
      .ptr   (rr_ptr_reg),
      .found (rr_found),
      .idx   (rr_idx)
   );

   // Per-station starvation tracking; waiting under cdb_hold still counts.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_age
         assign forced_vec[gi] = req[gi] && (age_reg[gi] == AGE_MAX);
         assign age_next[gi]   = (!req[gi] || grant[gi]) ? '0 :
                                 (age_reg[gi] == AGE_MAX) ? AGE_MAX :
                                 age_reg[gi] + AW'(1);
      end
   endgenerate

   always_comb begin
      forced_found = 1'b0;
      forced_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (forced_vec[i]) begin
            forced_found = 1'b1;
            forced_idx   = RW'(i);
         end
      end
   end

   always_comb begin
      win_idx = rr_idx;
      if (forced_found)
         win_idx = forced_idx;
      else if (cf_found)
         win_idx = RW'(CF_BASE) + RW'(cf_idx);
      win_cf      = (int'(win_idx) >= CF_BASE) && (int'(win_idx) < CF_BASE + NUM_CF);
      win_cf_off  = CW'(win_idx - RW'(CF_BASE));
      rr_ptr_next = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + RW'(1);
      cf_ptr_next = (int'(win_cf_off) == NUM_CF - 1) ? '0 : win_cf_off + CW'(1);
   end

   // rr_found is implied by |req; kept in the qualifier for clarity of intent.
   assign grant_valid = reset_n && !flush && !cdb_hold && rr_found;

   assign sel_load  = grant_valid;
   assign selection = grant_valid ? 32'(rs_id_of_req(int'(win_idx))) : 32'(RES_INVALID);
   assign grant     = grant_valid ? (NUM_REQ'(1) << win_idx) : '0;
   assign grant_cf  = grant_valid && win_cf;

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         rr_ptr_reg <= '0;
         cf_ptr_reg <= '0;
         age_reg    <= '0;
      end else begin
         age_reg <= age_next;
         if (grant_valid) begin
            rr_ptr_reg <= rr_ptr_next;
            if (win_cf)
               cf_ptr_reg <= cf_ptr_next;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed checks of cdb_arbiter against a behavioural arbitration model.
module tb_cdb_arbiter;

   localparam int NREQ = 16;
   localparam int CFB  = 12;
   localparam int NCF  = 4;
   localparam int LIM  = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NREQ-1:0]   req;
   logic              cdb_hold;
   logic              flush;
   logic [31:0]       selection;
   logic              sel_load;
   logic [NREQ-1:0]   grant;
   logic              grant_cf;

   int err_cnt = 0;
   int chk_cnt = 0;
   int txn     = 0;

   int m_age[NREQ];
   int m_rr;
   int m_cf;

   always #5 clk = ~clk;

   cdb_arbiter #(
      .NUM_REQ      (NREQ),
      .CF_BASE      (CFB),
      .NUM_CF       (NCF),
      .STARVE_LIMIT (LIM)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .cdb_hold  (cdb_hold),
      .flush     (flush),
      .selection (selection),
      .sel_load  (sel_load),
      .grant     (grant),
      .grant_cf  (grant_cf)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s txn=%0d got=%0h exp=%0h", tag, txn, got, exp);
      end
   endtask

   // One arbitration cycle: drive, compare against model, then advance model at the edge.
   task automatic cyc(input logic [NREQ-1:0] r, input bit h, input bit f, input bit rn,
                      output int sel_o);
      int  w;
      bit  gv;
      int  exp_sel;
      logic [NREQ-1:0] exp_grant;
      bit  exp_cf;
      @(negedge clk);
      req = r; cdb_hold = h; flush = f; reset_n = rn;
      #1;
      gv = rn && !f && !h && (r != '0);
      w  = -1;
      if (gv) begin
         for (int i = 0; i < NREQ && w < 0; i++)
            if (r[i] && m_age[i] == LIM) w = i;
         for (int k = 0; k < NCF && w < 0; k++)
            if (r[CFB + (m_cf + k) % NCF]) w = CFB + (m_cf + k) % NCF;
         for (int k = 0; k < NREQ && w < 0; k++)
            if (r[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
      end
      exp_sel   = gv ? w + 1 : 0;
      exp_grant = gv ? (NREQ'(1) << w) : '0;
      exp_cf    = gv && (w >= CFB) && (w < CFB + NCF);
      check_val("selection", selection, 32'(exp_sel));
      check_val("sel_load", 32'(sel_load), 32'(gv));
      check_val("grant", 32'(grant), 32'(exp_grant));
      check_val("grant_cf", 32'(grant_cf), 32'(exp_cf));
      sel_o = int'(selection);
      $display("txn=%0d rst_n=%0b hold=%0b flush=%0b req=%04h sel=%0d exp=%0d",
               txn, rn, h, f, r, selection, exp_sel);
      txn++;
      @(posedge clk);
      if (!rn || f) begin
         m_rr = 0; m_cf = 0;
         for (int i = 0; i < NREQ; i++) m_age[i] = 0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (!r[i] || (gv && w == i)) m_age[i] = 0;
            else if (m_age[i] < LIM)     m_age[i] = m_age[i] + 1;
         end
         if (gv) begin
            m_rr = (w + 1) % NREQ;
            if (w >= CFB && w < CFB + NCF) m_cf = (w - CFB + 1) % NCF;
         end
      end
   endtask

   initial begin
      int s;
      int rr_exp[5];
      int st_exp[6];
      bit h, f, rn;
      logic [NREQ-1:0] r;
      reset_n = 1'b0; req = '0; cdb_hold = 1'b0; flush = 1'b0;
      m_rr = 0; m_cf = 0;
      for (int i = 0; i < NREQ; i++) m_age[i] = 0;

      // Reset with everything requesting, then first grant goes to the first CF station.
      cyc(16'hFFFF, 0, 0, 0, s);  check_val("rst_sel", 32'(s), 32'd0);
      cyc(16'hFFFF, 0, 0, 0, s);  check_val("rst_sel", 32'(s), 32'd0);
      cyc(16'hFFFF, 0, 0, 1, s);  check_val("first_grant", 32'(s), 32'd13);

      // CF station beats general ones, then general round robin resumes.
      cyc(16'h2009, 0, 0, 1, s);  check_val("cf_prio", 32'(s), 32'd14);
      cyc(16'h0009, 0, 0, 1, s);  check_val("after_cf", 32'(s), 32'd1);

      // Plain round robin over four general stations.
      cyc(16'h0000, 0, 1, 1, s);
      rr_exp = '{1, 2, 3, 4, 1};
      for (int i = 0; i < 5; i++) begin
         cyc(16'h000F, 0, 0, 1, s);
         check_val("round_robin", 32'(s), 32'(rr_exp[i]));
      end

      // Station 5 starved by a persistent CF requester gets forced on the 5th cycle.
      cyc(16'h0000, 0, 1, 1, s);
      st_exp = '{13, 13, 13, 13, 6, 13};
      for (int i = 0; i < 6; i++) begin
         cyc(16'h1020, 0, 0, 1, s);
         check_val("starve", 32'(s), 32'(st_exp[i]));
      end

      // Hold blocks grants; flush (even with hold) blocks and clears; then station 2 wins.
      cyc(16'h0000, 0, 1, 1, s);
      for (int i = 0; i < 3; i++) begin
         cyc(16'h0004, 1, 0, 1, s);
         check_val("hold", 32'(s), 32'd0);
      end
      cyc(16'h0004, 1, 1, 1, s);  check_val("flush", 32'(s), 32'd0);
      cyc(16'h0004, 0, 0, 1, s);  check_val("post_flush", 32'(s), 32'd3);

      // CF pointer wrap: park cf_ptr at 3, then 15 wins before 12.
      cyc(16'h0000, 0, 1, 1, s);
      cyc(16'h4000, 0, 0, 1, s);  check_val("cf_park", 32'(s), 32'd15);
      cyc(16'h9000, 0, 0, 1, s);  check_val("cf_wrap0", 32'(s), 32'd16);
      cyc(16'h9000, 0, 0, 1, s);  check_val("cf_wrap1", 32'(s), 32'd13);

      // Randomized traffic including mid-stream reset, hold and flush.
      for (int n = 0; n < 800; n++) begin
         case ($urandom_range(3))
            0:       r = NREQ'($urandom);
            1:       r = NREQ'($urandom & $urandom);
            2:       r = NREQ'($urandom & $urandom & $urandom);
            default: r = NREQ'(16'h1000 | ($urandom & 16'h00FF));
         endcase
         h  = ($urandom_range(7) == 0);
         f  = ($urandom_range(15) == 0);
         rn = ($urandom_range(31) != 0);
         cyc(r, h, f, rn, s);
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
